// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshake and memory bus bundle for mem_arbiter
interface mem_arbiter_if #(parameter int AW = 12, parameter int DW = 16);
  logic          en0, en1, rdwr0, rdwr1, ack0, ack1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          mem_en, mem_rdwr, mem_ack, err;
  logic [1:0]    gnt;
  modport slave (
    input  en0, en1, rdwr0, rdwr1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
    output rdata0, rdata1, ack0, ack1, mem_en, mem_rdwr, mem_addr, mem_wdata, gnt, err
  );
  modport master (
    output en0, en1, rdwr0, rdwr1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
    input  rdata0, rdata1, ack0, ack1, mem_en, mem_rdwr, mem_addr, mem_wdata, gnt, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter onto one memory; ARB_TIMEOUT_EN adds mem_ack timeout abort
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t        state_q;
  logic          last_q, mem_en_q, mem_rdwr_q, ack0_q, ack1_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, rdata0_q, rdata1_q;
  logic [1:0]    gnt_q;
  logic          win_d, own_en_d, expire_d;
  logic [DW-1:0] rd_d;
  assign win_d    = (bus.en0 && bus.en1) ? ~last_q : bus.en1;
  assign own_en_d = last_q ? bus.en1 : bus.en0;
  assign rd_d     = bus.mem_ack ? bus.mem_rdata : DW'(16'hDEAD);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign expire_d = cnt_q == CW'(TIMEOUT - 1);
  assign bus.err  = err_q;
`else
  assign expire_d = 1'b0;
  assign bus.err  = 1'b0;
`endif
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_rdwr  = mem_rdwr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.gnt       = gnt_q;
  // Arbitration FSM: grant in IDLE, wait for completion in BUSY, finish handshake in RELEASE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_rdwr_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      gnt_q       <= 2'b00;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (!bus.mem_ack && (bus.en0 || bus.en1)) begin
          state_q     <= BUSY;
          last_q      <= win_d;
          gnt_q       <= win_d ? 2'b10 : 2'b01;
          mem_en_q    <= 1'b1;
          mem_rdwr_q  <= win_d ? bus.rdwr1 : bus.rdwr0;
          mem_addr_q  <= win_d ? bus.addr1 : bus.addr0;
          mem_wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
`ifdef ARB_TIMEOUT_EN
          cnt_q       <= '0;
`endif
        end
        BUSY: begin
          if (bus.mem_ack || expire_d) begin
            state_q  <= RELEASE;
            mem_en_q <= 1'b0;
            if (!last_q && bus.en0) begin
              ack0_q <= 1'b1;
              if (!mem_rdwr_q || !bus.mem_ack) rdata0_q <= rd_d;
            end
            if (last_q && bus.en1) begin
              ack1_q <= 1'b1;
              if (!mem_rdwr_q || !bus.mem_ack) rdata1_q <= rd_d;
            end
          end
`ifdef ARB_TIMEOUT_EN
          if (!bus.mem_ack && expire_d) err_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
`endif
        end
        RELEASE: if (!own_en_d && !bus.mem_ack) begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt_q   <= 2'b00;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a four-phase memory responder
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [1:0] gnt; logic rdwr; logic [11:0] addr; logic [15:0] wdata;} txn_t;
  txn_t sb[$];
  txn_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   dly = 1;
  bit   stall = 1'b0;
  int   mcnt;
  logic pe;
  logic [15:0] pr0, pr1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] mdat(input logic [11:0] a);
    return {4'h0, a} + 16'h7003;
  endfunction
  function automatic logic ack_of(input bit p);
    return p ? bus.ack1 : bus.ack0;
  endfunction
  function automatic logic [15:0] rdata_of(input bit p);
    return p ? bus.rdata1 : bus.rdata0;
  endfunction
  task automatic drive(input bit p, input logic e, input logic rw, input logic [11:0] a, input logic [15:0] d);
    if (p) begin
      bus.en1 = e; bus.rdwr1 = rw; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.en0 = e; bus.rdwr0 = rw; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask
  task automatic push(input logic [1:0] g, input logic rw, input logic [11:0] a, input logic [15:0] d);
    sb.push_back('{g, rw, a, d});
  endtask
  task automatic req(input bit p, input logic rw, input logic [11:0] a, input logic [15:0] d, input bit drop, input bit lat);
    int k;
    logic [15:0] keep;
    @(negedge clk);
    keep = rdata_of(p);
    drive(p, 1'b1, rw, a, d);
    if (lat) begin
      @(posedge clk); #1;
      check("req_to_mem_en", bus.mem_en, 1);
    end
    k = 0;
    while (!(bus.mem_en && bus.gnt[p]) && k < 200) begin @(negedge clk); k++; end
    check("grant_seen", k < 200, 1);
    if (drop) begin
      drive(p, 1'b0, ~rw, ~a, ~d);
      k = 0;
      while (bus.gnt != 2'b00 && k < 200) begin
        @(negedge clk); k++;
        check("no_ack_after_drop", ack_of(p), 0);
      end
      check("idle_after_drop", bus.gnt, 0);
      check("rdata_kept", rdata_of(p), keep);
    end else begin
      drive(p, 1'b1, ~rw, ~a, ~d);
      k = 0;
      while (!ack_of(p) && k < 200) begin @(negedge clk); k++; end
      check("ack", ack_of(p), 1);
      if (!rw) check("rdata", rdata_of(p), mdat(a));
      @(negedge clk);
      check("ack_held", ack_of(p), 1);
      drive(p, 1'b0, rw, a, d);
      k = 0;
      while (ack_of(p) && k < 200) begin @(negedge clk); k++; end
      check("ack_drop", ack_of(p), 0);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  // Memory responder: acks dly+1 cycles after mem_en, holds ack until mem_en drops
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= 16'h0;
      mcnt          <= 0;
    end else if (bus.mem_en && !bus.mem_ack && !stall) begin
      if (mcnt >= dly) begin
        bus.mem_ack   <= 1'b1;
        bus.mem_rdata <= mdat(bus.mem_addr);
        mcnt          <= 0;
      end else mcnt <= mcnt + 1;
    end else if (!bus.mem_en) bus.mem_ack <= 1'b0;
  end
  // Monitor: pop expected transaction on each mem_en rise, check bus stability and rdata ownership
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pe = 1'b0;
    end else begin
      if (bus.mem_en && !pe) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check("gnt", bus.gnt, cur.gnt);
          check("mem_rdwr", bus.mem_rdwr, cur.rdwr);
          check("mem_addr", bus.mem_addr, cur.addr);
          check("mem_wdata", bus.mem_wdata, cur.wdata);
        end
      end else if (bus.mem_en) begin
        check("mem_addr_stable", bus.mem_addr, cur.addr);
        check("mem_wdata_stable", bus.mem_wdata, cur.wdata);
      end
      if (bus.rdata0 != pr0) check("rdata0_owner", bus.gnt[0], 1);
      if (bus.rdata1 != pr1) check("rdata1_owner", bus.gnt[1], 1);
      pe = bus.mem_en;
    end
    pr0 = bus.rdata0;
    pr1 = bus.rdata1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 12'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_ack", {bus.ack1, bus.ack0}, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    push(2'b01, 1'b0, 12'h010, 16'h0);
    req(1'b0, 1'b0, 12'h010, 16'h0, 1'b0, 1'b1);
    check("t1_gnt_idle", bus.gnt, 0);
    do_reset();
    push(2'b01, 1'b1, 12'h100, 16'h1111);
    push(2'b10, 1'b1, 12'h200, 16'h2222);
    fork
      req(1'b0, 1'b1, 12'h100, 16'h1111, 1'b0, 1'b0);
      req(1'b1, 1'b1, 12'h200, 16'h2222, 1'b0, 1'b0);
    join
    for (int i = 0; i < 2; i++) begin
      push(2'b01, 1'b0, 12'h040 + 12'(i), 16'h0);
      push(2'b10, 1'b1, 12'h080 + 12'(i), 16'hA000 + 16'(i));
    end
    fork
      for (int i = 0; i < 2; i++) req(1'b0, 1'b0, 12'h040 + 12'(i), 16'h0, 1'b0, 1'b0);
      for (int j = 0; j < 2; j++) req(1'b1, 1'b1, 12'h080 + 12'(j), 16'hA000 + 16'(j), 1'b0, 1'b0);
    join
    dly = 4;
    push(2'b01, 1'b0, 12'h123, 16'h0);
    push(2'b10, 1'b1, 12'h3FF, 16'hBEEF);
    fork
      req(1'b0, 1'b0, 12'h123, 16'h0, 1'b0, 1'b0);
      begin @(negedge clk); req(1'b1, 1'b1, 12'h3FF, 16'hBEEF, 1'b0, 1'b0); end
    join
    dly = 3;
    push(2'b01, 1'b0, 12'h055, 16'h0);
    req(1'b0, 1'b0, 12'h055, 16'h0, 1'b1, 1'b0);
    push(2'b01, 1'b0, 12'h066, 16'h0);
    req(1'b0, 1'b0, 12'h066, 16'h0, 1'b0, 1'b1);
    dly = 1;
    stall = 1'b1;
    push(2'b01, 1'b0, 12'h077, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 12'h077, 16'h0);
    k = 0;
    while (!bus.mem_en && k < 50) begin @(negedge clk); k++; end
    check("t5_mem_en", bus.mem_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_mem_en_drop", bus.mem_en, 0);
    check("t5_ack", {bus.ack1, bus.ack0}, 0);
    check("t5_gnt", bus.gnt, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    rst = 1'b0;
    stall = 1'b0;
    push(2'b01, 1'b1, 12'h011, 16'h5A5A);
    push(2'b10, 1'b1, 12'h022, 16'hA5A5);
    fork
      req(1'b0, 1'b1, 12'h011, 16'h5A5A, 1'b0, 1'b0);
      req(1'b1, 1'b1, 12'h022, 16'hA5A5, 1'b0, 1'b0);
    join
`ifdef ARB_TIMEOUT_EN
    stall = 1'b1;
    push(2'b01, 1'b0, 12'h0AA, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 12'h0AA, 16'h0);
    k = 0;
    while (!bus.ack0 && k < 100) begin @(negedge clk); k++; end
    check("t6_latency", k, 16);
    check("t6_rdata", bus.rdata0, 16'hDEAD);
    check("t6_err", bus.err, 1);
    drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    stall = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_err_sticky", bus.err, 1);
    do_reset();
    check("t6_err_cleared", bus.err, 0);
`else
    check("err_tied", bus.err, 0);
`endif
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
